// File: rtl/irs_block_readout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : irs_block_readout
//  Description : Digitizes and reads out one IRS2/IRS3 analog-storage block
//                per request. Latches the block address, selects it on the
//                IRS read bus, runs the Wilkinson ramp and then scans every
//                enabled channel x 64 samples, streaming each 12-bit sample
//                to the event buffer.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i / rst_n_i          clock, asynchronous active-low reset
//    rst_ack_o                high in reset and for the first clock after it
//    raddr_i/raddr_stb_i      block request (level-held until raddr_ack_o)
//    raddr_ack_o              one-clock accept pulse
//    ch_mask_i / irs_mode_i   channel enables / 0=IRS2 1=IRS3, latched at accept
//    block_*_o                event-buffer stream (addr, mask, data, start,
//                             valid, done)
//    irs_*                    IRS ASIC pins (read address, sample/channel
//                             select, Wilkinson control, data in, status)
//    debug_o                  packed state/ch/smp/addr/data/valid/ramp
// ============================================================================
module irs_block_readout #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CONV_CYCLES   = 512,
    parameter int SMP_WAIT      = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        rst_ack_o,
    input  logic [8:0]  raddr_i,
    input  logic        raddr_stb_i,
    output logic        raddr_ack_o,
    input  logic [7:0]  ch_mask_i,
    input  logic        irs_mode_i,
    output logic [8:0]  block_addr_o,
    output logic [11:0] block_dat_o,
    output logic        block_start_o,
    output logic        block_valid_o,
    output logic        block_done_o,
    output logic [7:0]  block_mask_o,
    output logic [9:0]  irs_rd_o,
    output logic        irs_rden_o,
    output logic [5:0]  irs_smp_o,
    output logic [2:0]  irs_ch_o,
    output logic        irs_smpall_o,
    input  logic [11:0] irs_dat_i,
    output logic        irs_start_o,
    output logic        irs_clr_o,
    output logic        irs_ramp_o,
    output logic        irs_address_sel_o,
    output logic        irs_ramping_o,
    output logic        irs_readout_o,
    output logic [47:0] debug_o
);

    localparam int CNT_MAX = (SETTLE_CYCLES > CONV_CYCLES) ? SETTLE_CYCLES : CONV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int WAIT_W  = $clog2(SMP_WAIT + 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ADDR  = 4'd1,
        S_CLEAR = 4'd2,
        S_RAMP  = 4'd3,
        S_READ  = 4'd4,
        S_DONE  = 4'd5
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WAIT_W-1:0]  wt, wt_nxt;
    logic [2:0]         ch, ch_nxt;
    logic [5:0]         smp, smp_nxt;
    logic               flush, flush_nxt;
    logic [8:0]         addr, addr_nxt;
    logic [7:0]         mask, mask_nxt;
    logic               mode, mode_nxt;

    logic               ack_nxt, start_nxt, valid_nxt, done_nxt;
    logic [11:0]        dat_nxt;
    logic               rden_nxt, clr_nxt, ramp_nxt, asel_nxt, smpall_nxt, readout_nxt;
    logic [47:0]        debug_nxt;
    logic               ramp_q;

    // Channel search over the latched mask: lowest enabled channel, and the
    // next enabled channel above the current one (disabled ones cost no time).
    logic [2:0]         first_ch, next_ch;
    logic               has_next;

    always_comb begin
        first_ch = 3'd0;
        next_ch  = 3'd0;
        has_next = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                first_ch = 3'(i);
            end
            if (mask[i] && (i > int'(ch))) begin
                next_ch  = 3'(i);
                has_next = 1'b1;
            end
        end
    end

    // Next-state and next-output logic. Every output is a flop loaded from
    // these values, so outputs line up with the state they describe.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wt_nxt    = wt;
        ch_nxt    = ch;
        smp_nxt   = smp;
        flush_nxt = flush;
        addr_nxt  = addr;
        mask_nxt  = mask;
        mode_nxt  = mode;
        ack_nxt   = 1'b0;
        start_nxt = 1'b0;
        valid_nxt = 1'b0;
        dat_nxt   = block_dat_o;

        case (state)
            S_IDLE: begin
                if (raddr_stb_i) begin
                    addr_nxt  = raddr_i;
                    mask_nxt  = ch_mask_i;
                    mode_nxt  = irs_mode_i;
                    ack_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_nxt = S_CLEAR;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_CLEAR: begin
                cnt_nxt   = '0;
                state_nxt = S_RAMP;
            end
            S_RAMP: begin
                if (cnt == CNT_W'(CONV_CYCLES - 1)) begin
                    state_nxt = S_READ;
                    start_nxt = 1'b1;
                    ch_nxt    = first_ch;
                    smp_nxt   = 6'd0;
                    wt_nxt    = '0;
                    flush_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_READ: begin
                // flush is the extra READ clock in which the final word is
                // presented; done follows it one clock later.
                if (flush || (mask == 8'd0)) begin
                    state_nxt = S_DONE;
                    flush_nxt = 1'b0;
                    ch_nxt    = 3'd0;
                    smp_nxt   = 6'd0;
                end else if (wt == WAIT_W'(SMP_WAIT - 1)) begin
                    valid_nxt = 1'b1;
                    dat_nxt   = irs_dat_i;
                    wt_nxt    = '0;
                    if (smp == 6'd63) begin
                        smp_nxt = 6'd0;
                        if (has_next) begin
                            ch_nxt = next_ch;
                        end else begin
                            ch_nxt    = 3'd0;
                            flush_nxt = 1'b1;
                        end
                    end else begin
                        smp_nxt = smp + 6'd1;
                    end
                end else begin
                    wt_nxt = wt + WAIT_W'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        done_nxt    = (state_nxt == S_DONE);
        rden_nxt    = (state_nxt == S_ADDR) || (state_nxt == S_RAMP);
        clr_nxt     = (state_nxt == S_CLEAR);
        ramp_nxt    = (state_nxt == S_RAMP);
        readout_nxt = (state_nxt == S_READ);
        asel_nxt    = mode_nxt && ((state_nxt == S_ADDR) || (state_nxt == S_CLEAR) ||
                                   (state_nxt == S_RAMP));
        smpall_nxt  = mode_nxt && (state_nxt == S_READ);
        debug_nxt   = {12'd0, ramp_nxt, valid_nxt, irs_dat_i, addr_nxt,
                       smp_nxt, ch_nxt, state_nxt};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rst_ack_o         <= 1'b1;
            cnt               <= '0;
            wt                <= '0;
            ch                <= 3'd0;
            smp               <= 6'd0;
            flush             <= 1'b0;
            addr              <= 9'd0;
            mask              <= 8'd0;
            mode              <= 1'b0;
            raddr_ack_o       <= 1'b0;
            block_start_o     <= 1'b0;
            block_valid_o     <= 1'b0;
            block_done_o      <= 1'b0;
            block_dat_o       <= 12'd0;
            irs_rden_o        <= 1'b0;
            irs_clr_o         <= 1'b0;
            ramp_q            <= 1'b0;
            irs_address_sel_o <= 1'b0;
            irs_smpall_o      <= 1'b0;
            irs_readout_o     <= 1'b0;
            debug_o           <= 48'd0;
        end else begin
            rst_ack_o         <= 1'b0;
            cnt               <= cnt_nxt;
            wt                <= wt_nxt;
            ch                <= ch_nxt;
            smp               <= smp_nxt;
            flush             <= flush_nxt;
            addr              <= addr_nxt;
            mask              <= mask_nxt;
            mode              <= mode_nxt;
            raddr_ack_o       <= ack_nxt;
            block_start_o     <= start_nxt;
            block_valid_o     <= valid_nxt;
            block_done_o      <= done_nxt;
            block_dat_o       <= dat_nxt;
            irs_rden_o        <= rden_nxt;
            irs_clr_o         <= clr_nxt;
            ramp_q            <= ramp_nxt;
            irs_address_sel_o <= asel_nxt;
            irs_smpall_o      <= smpall_nxt;
            irs_readout_o     <= readout_nxt;
            debug_o           <= debug_nxt;
        end
    end

    assign block_addr_o  = addr;
    assign block_mask_o  = mask;
    assign irs_rd_o      = {mode, addr};
    assign irs_smp_o     = smp;
    assign irs_ch_o      = ch;
    assign irs_ramp_o    = ramp_q;
    assign irs_start_o   = ramp_q;
    assign irs_ramping_o = ramp_q;

endmodule
`default_nettype wire

// File: tb/tb_irs_block_readout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_irs_block_readout
//  Description : Self-checking bench for irs_block_readout. The IRS model
//                returns a known word only once a channel/sample address has
//                been held for the full slot; the expected stream is built
//                from the enabled channel list.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_irs_block_readout;

    localparam int SETTLE = 4;
    localparam int CONV   = 512;
    localparam int SW     = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_ack;
    logic [8:0]  raddr;
    logic        raddr_stb;
    logic        raddr_ack;
    logic [7:0]  ch_mask;
    logic        irs_mode;
    logic [8:0]  block_addr;
    logic [11:0] block_dat;
    logic        block_start, block_valid, block_done;
    logic [7:0]  block_mask;
    logic [9:0]  irs_rd;
    logic        irs_rden;
    logic [5:0]  irs_smp;
    logic [2:0]  irs_ch;
    logic        irs_smpall;
    logic [11:0] irs_dat;
    logic        irs_start, irs_clr, irs_ramp, irs_address_sel, irs_ramping, irs_readout;
    logic [47:0] debug;

    always #5 clk = ~clk;

    irs_block_readout #(
        .SETTLE_CYCLES(SETTLE),
        .CONV_CYCLES  (CONV),
        .SMP_WAIT     (SW)
    ) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .rst_ack_o        (rst_ack),
        .raddr_i          (raddr),
        .raddr_stb_i      (raddr_stb),
        .raddr_ack_o      (raddr_ack),
        .ch_mask_i        (ch_mask),
        .irs_mode_i       (irs_mode),
        .block_addr_o     (block_addr),
        .block_dat_o      (block_dat),
        .block_start_o    (block_start),
        .block_valid_o    (block_valid),
        .block_done_o     (block_done),
        .block_mask_o     (block_mask),
        .irs_rd_o         (irs_rd),
        .irs_rden_o       (irs_rden),
        .irs_smp_o        (irs_smp),
        .irs_ch_o         (irs_ch),
        .irs_smpall_o     (irs_smpall),
        .irs_dat_i        (irs_dat),
        .irs_start_o      (irs_start),
        .irs_clr_o        (irs_clr),
        .irs_ramp_o       (irs_ramp),
        .irs_address_sel_o(irs_address_sel),
        .irs_ramping_o    (irs_ramping),
        .irs_readout_o    (irs_readout),
        .debug_o          (debug)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // IRS data model: a channel/sample address must be held SW clocks
    // before the pins carry its word; earlier clocks carry noise.
    logic [11:0] salt = 12'd0;
    logic [9:0]  key_prev = 10'h3FF;
    int          hold = 0;

    function automatic logic [11:0] sample_word(input int c, input int s, input logic [11:0] sl);
        return 12'(c * 64 + s) ^ sl;
    endfunction

    always @(negedge clk) begin
        if ({irs_readout, irs_ch, irs_smp} == key_prev) hold++;
        else hold = 1;
        key_prev = {irs_readout, irs_ch, irs_smp};
        irs_dat  = (hold == SW) ? sample_word(int'(irs_ch), int'(irs_smp), salt) : 12'($urandom);
    end

    function automatic logic [63:0] all_outs();
        return {4'd0, raddr_ack, block_addr, block_dat, block_start, block_valid, block_done,
                block_mask, irs_rd, irs_rden, irs_smp, irs_ch, irs_smpall, irs_start,
                irs_clr, irs_ramp, irs_address_sel, irs_ramping, irs_readout};
    endfunction

    task automatic request(input logic [8:0] a, input logic [7:0] m, input logic md);
        raddr     = a;
        ch_mask   = m;
        irs_mode  = md;
        raddr_stb = 1'b1;
    endtask

    // Wait for the accept, then follow one block to its done pulse and check
    // it against the expected word list and phase lengths.
    task automatic run_block(input string tag, input logic [8:0] a, input logic [7:0] m,
                             input logic md, input logic chain, input logic [8:0] a2,
                             input logic [7:0] m2, input logic md2);
        logic [11:0] expq[$];
        int  pop, nrden, nclr, nramp, nstart, ndone, nack, nasel, nsmpall, nread;
        int  nv, start_t, done_t, last_v, bad_gap, bad_idle, exp_read;
        bit  got;
        pop = 0;
        for (int c = 0; c < 8; c++) begin
            if (m[c]) begin
                pop++;
                for (int s = 0; s < 64; s++) expq.push_back(sample_word(c, s, salt));
            end
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (raddr_ack) got = 1'b1;
        end
        check({tag, " ack"}, 64'(got), 64'd1);
        if (!got) return;
        check({tag, " block_addr"}, 64'(block_addr), 64'(a));
        check({tag, " irs_rd"}, 64'(irs_rd), 64'({md, a}));
        check({tag, " block_mask"}, 64'(block_mask), 64'(m));
        if (chain) begin
            raddr = a2; ch_mask = m2; irs_mode = md2;
        end else begin
            raddr_stb = 1'b0;
        end
        nrden = int'(irs_rden); nasel = int'(irs_address_sel);
        nclr = 0; nramp = 0; nstart = 0; ndone = 0; nack = 0; nsmpall = 0; nread = 0;
        nv = 0; start_t = -1; done_t = -1; last_v = -1; bad_gap = 0; bad_idle = 0;
        for (int t = 0; t < 4000 && done_t < 0; t++) begin
            @(negedge clk);
            nack    += int'(raddr_ack);
            nrden   += int'(irs_rden);
            nclr    += int'(irs_clr);
            nramp   += int'(irs_ramp && irs_start && irs_ramping);
            nasel   += int'(irs_address_sel);
            nsmpall += int'(irs_smpall);
            nread   += int'(irs_readout);
            if (!irs_readout && (irs_ch != 3'd0 || irs_smp != 6'd0)) bad_idle++;
            if (block_start) begin nstart++; start_t = t; end
            if (block_valid) begin
                if (expq.size() == 0) begin
                    check({tag, " extra_valid"}, 64'd1, 64'd0);
                end else begin
                    check({tag, " dat"}, 64'(block_dat), 64'(expq.pop_front()));
                end
                if (t - ((last_v < 0) ? start_t : last_v) != SW) bad_gap++;
                last_v = t;
                nv++;
            end
            if (block_done) begin ndone++; done_t = t; end
        end
        exp_read = (pop == 0) ? 1 : pop * 64 * SW + 1;
        check({tag, " done"}, 64'(ndone), 64'd1);
        check({tag, " start"}, 64'(nstart), 64'd1);
        check({tag, " words"}, 64'(nv), 64'(pop * 64));
        check({tag, " ramp_len"}, 64'(nramp), 64'(CONV));
        check({tag, " rden_len"}, 64'(nrden), 64'(SETTLE + CONV));
        check({tag, " clr_len"}, 64'(nclr), 64'd1);
        check({tag, " read_len"}, 64'(nread), 64'(exp_read));
        check({tag, " addr_sel"}, 64'(nasel), md ? 64'(SETTLE + 1 + CONV) : 64'd0);
        check({tag, " smpall"}, 64'(nsmpall), md ? 64'(exp_read) : 64'd0);
        check({tag, " extra_ack"}, 64'(nack), 64'd0);
        check({tag, " word_spacing"}, 64'(bad_gap), 64'd0);
        check({tag, " idle_ch_smp"}, 64'(bad_idle), 64'd0);
        check({tag, " done_delay"}, 64'(done_t - ((pop == 0) ? start_t : last_v)), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; raddr = 9'd0; raddr_stb = 1'b0; ch_mask = 8'd0; irs_mode = 1'b0;
        // Reset behaviour
        repeat (5) @(negedge clk);
        check("rst rst_ack", 64'(rst_ack), 64'd1);
        check("rst outputs", all_outs(), 64'd0);
        check("rst debug", 64'(debug), 64'd0);
        rst_n = 1'b1;
        #1 check("rel rst_ack_hold", 64'(rst_ack), 64'd1);
        @(negedge clk);
        check("rel rst_ack", 64'(rst_ack), 64'd0);

        // IRS3 full mask, with a second request held during the block
        salt = 12'd0;
        request(9'h000, 8'hFF, 1'b1);
        run_block("t2", 9'h000, 8'hFF, 1'b1, 1'b1, 9'h001, 8'hFF, 1'b1);
        run_block("t3", 9'h001, 8'hFF, 1'b1, 1'b0, 9'h000, 8'h00, 1'b0);

        // IRS2, channels 0 and 2, data = ch*64+smp
        repeat (3) @(negedge clk);
        salt = 12'd0;
        request(9'h0AB, 8'h05, 1'b0);
        run_block("t4", 9'h0AB, 8'h05, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0);

        // Empty mask
        request(9'h1F0, 8'h00, 1'b1);
        run_block("t5", 9'h1F0, 8'h00, 1'b1, 1'b0, 9'h000, 8'h00, 1'b0);

        // Abort during the ramp
        request(9'h155, 8'h81, 1'b1);
        begin
            bit got;
            int bad;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (raddr_ack) got = 1'b1;
            end
            check("t6 ack", 64'(got), 64'd1);
            raddr_stb = 1'b0;
            repeat (100) @(negedge clk);
            check("t6 in_ramp", 64'(irs_ramp), 64'd1);
            rst_n = 1'b0;
            #1;
            check("t6 abort outputs", all_outs(), 64'd0);
            check("t6 abort debug", 64'(debug), 64'd0);
            check("t6 abort rst_ack", 64'(rst_ack), 64'd1);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            bad = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                bad += int'(block_valid || block_done || block_start || raddr_ack);
            end
            check("t6 no_partial", 64'(bad), 64'd0);
        end
        salt = 12'h5A3;
        request(9'h0C3, 8'h12, 1'b0);
        run_block("t6 after", 9'h0C3, 8'h12, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0);

        // Randomized blocks
        for (int k = 0; k < 6; k++) begin
            logic [8:0] a;
            logic [7:0] m;
            logic       md;
            a    = 9'($urandom);
            m    = 8'($urandom);
            md   = 1'($urandom);
            salt = 12'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            request(a, m, md);
            run_block($sformatf("rnd%0d", k), a, m, md, 1'b0, 9'h000, 8'h00, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
